// File: rtl/lane_demand_pkg.sv
// lane_demand_pkg: shared widths, class limits and class validity check for the lane demand monitor
package lane_demand_pkg;
    localparam int NLANE = 4;
    localparam int LANE_W = 3;
    localparam int CLASS_W = 5;
    localparam int CLASS_MIN = 1;
    localparam int CLASS_MAX = 26;
    localparam int EMERG_CLASS = 26;

    function automatic logic is_valid_class(input logic [CLASS_W-1:0] c);
        return c >= CLASS_W'(CLASS_MIN) && c <= CLASS_W'(CLASS_MAX);
    endfunction
endpackage

// File: rtl/lane_counter.sv
// lane_counter: per-lane saturating vehicle count with clear/halve, plus emergency hold timer
module lane_counter #(
    parameter int CNT_W = 6,
    parameter int EMERG_HOLD = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             halve,
    input  logic             inc,
    input  logic             load,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nx,
    output logic             emerg
);
    localparam int HOLD_W = $clog2(EMERG_HOLD + 1);

    logic [HOLD_W-1:0] hold, hold_nx;

    // clear beats halve beats increment; increment and halve never coincide
    always_comb begin
        count_nx = clear ? '0 : halve ? count >> 1 : (inc && count != '1) ? count + 1'b1 : count;
        hold_nx = load ? HOLD_W'(EMERG_HOLD) : (hold != '0) ? hold - 1'b1 : hold;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            hold <= '0;
            emerg <= 1'b0;
        end else begin
            count <= count_nx;
            hold <= hold_nx;
            emerg <= hold_nx != '0;
        end
    end
endmodule

// File: rtl/lane_demand_monitor.sv
// lane_demand_monitor: turns per-image classifications into load-priority (p) and emergency (e)
// request vectors, with windowed count decay and per-lane emergency hold.
module lane_demand_monitor
    import lane_demand_pkg::*;
#(
    parameter int CNT_W = 6,
    parameter int LOAD_THRESH = 8,
    parameter int WINDOW = 64,
    parameter int EMERG_HOLD = 32,
    parameter int EMERG_CLASS = lane_demand_pkg::EMERG_CLASS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cls_valid,
    output logic                   cls_ready,
    input  logic [LANE_W-1:0]      cls_lane,
    input  logic [CLASS_W-1:0]     cls_class,
    input  logic [NLANE-1:0]       served,
    output logic [NLANE-1:0]       p,
    output logic [NLANE-1:0]       e,
    output logic                   drop,
    output logic [NLANE*CNT_W-1:0] lane_count
);
    localparam int WIN_W = $clog2(WINDOW);

    logic [WIN_W-1:0] win, win_nx;
    logic tick, accept, good, take, em;
    logic [CNT_W-1:0] cnt_nx [NLANE];
    logic [CNT_W-1:0] best;
    logic [NLANE-1:0] p_nx;

    always_comb begin
        tick = win == WIN_W'(WINDOW - 1);
        win_nx = tick ? '0 : win + 1'b1;
        accept = cls_valid & cls_ready;
        good = cls_lane < LANE_W'(NLANE) && is_valid_class(cls_class);
        take = accept & good;
        em = take && cls_class == CLASS_W'(EMERG_CLASS);
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        lane_counter #(.CNT_W(CNT_W), .EMERG_HOLD(EMERG_HOLD)) u_lane (
            .clk(clk),
            .reset(reset),
            .clear(served[g]),
            .halve(tick),
            .inc(take && cls_lane == LANE_W'(g)),
            .load(em && cls_lane == LANE_W'(g)),
            .count(lane_count[g*CNT_W +: CNT_W]),
            .count_nx(cnt_nx[g]),
            .emerg(e[g])
        );
    end

    // strict compare keeps the lowest index on ties
    always_comb begin
        p_nx = '0;
        best = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (cnt_nx[i] >= CNT_W'(LOAD_THRESH) && cnt_nx[i] > best) begin
                best = cnt_nx[i];
                p_nx = '0;
                p_nx[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            win <= '0;
            p <= '0;
            drop <= 1'b0;
            cls_ready <= 1'b0;
        end else begin
            win <= win_nx;
            p <= p_nx;
            drop <= accept & ~good;
            cls_ready <= win_nx != WIN_W'(WINDOW - 1);
        end
    end
endmodule

// File: tb/tb_lane_demand_monitor.sv
// tb_lane_demand_monitor: directed and random stimulus checked every cycle against a
// time-based reference model (edge count since reset, last-emergency timestamps).
module tb_lane_demand_monitor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cls_valid = 1'b0;
    logic cls_ready;
    logic [2:0] cls_lane = '0;
    logic [4:0] cls_class = '0;
    logic [3:0] served = '0;
    logic [3:0] p, e;
    logic drop;
    logic [23:0] lane_count;

    int errors = 0;
    int checks = 0;
    int k = 0;
    int m_cnt[4];
    int last_em[4];
    bit has_em[4];
    bit m_drop = 0;

    lane_demand_monitor dut (
        .clk(clk),
        .reset(reset),
        .cls_valid(cls_valid),
        .cls_ready(cls_ready),
        .cls_lane(cls_lane),
        .cls_class(cls_class),
        .served(served),
        .p(p),
        .e(e),
        .drop(drop),
        .lane_count(lane_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return reset && k > 0 && k % 64 != 63;
    endfunction

    function automatic int m_p();
        int best = 7;
        int idx = -1;
        for (int i = 0; i < 4; i++)
            if (m_cnt[i] > best) begin
                best = m_cnt[i];
                idx = i;
            end
        return idx < 0 ? 0 : 1 << idx;
    endfunction

    function automatic int m_e();
        int r = 0;
        for (int i = 0; i < 4; i++)
            if (has_em[i] && k - last_em[i] < 32) r |= 1 << i;
        return r;
    endfunction

    task automatic step();
        bit acc, ok, tick;
        acc = cls_valid && m_ready();
        ok = cls_lane < 4 && cls_class >= 1 && cls_class <= 26;
        tick = k % 64 == 63;
        @(posedge clk);
        if (!reset) begin
            k = 0;
            m_drop = 0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                has_em[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if (served[i]) m_cnt[i] = 0;
                else if (tick) m_cnt[i] = m_cnt[i] / 2;
                else if (acc && ok && cls_lane == i) m_cnt[i] = m_cnt[i] < 63 ? m_cnt[i] + 1 : 63;
            k++;
            if (acc && ok && cls_class == 26) begin
                has_em[cls_lane] = 1;
                last_em[cls_lane] = k;
            end
            m_drop = acc && !ok;
        end
        #1;
        check("ready", cls_ready, m_ready());
        check("p", p, m_p());
        check("e", e, m_e());
        check("drop", drop, m_drop);
        for (int i = 0; i < 4; i++) check($sformatf("count%0d", i), lane_count[i*6 +: 6], m_cnt[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int lane, input int cls);
        bit acc = 0;
        cls_valid = 1;
        cls_lane = 3'(lane);
        cls_class = 5'(cls);
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = m_ready();
            step();
        end
        if (!acc) check("accept_timeout", 0, 1);
        cls_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            has_em[i] = 0;
            last_em[i] = 0;
        end
        cls_valid = 1;
        cls_lane = 2;
        cls_class = 5;
        idle(3);
        check("rst_ready", cls_ready, 0);
        check("rst_p", p, 0);
        check("rst_cnt", lane_count, 0);
        reset = 1;
        cls_valid = 0;
        idle(2);
        repeat (8) send(2, 5);
        check("t2_count2", lane_count[17:12], 8);
        check("t2_p", p, 4'b0100);
        served = 4'hF;
        step();
        served = 0;
        send(1, 26);
        idle(40);
        send(1, 26);
        idle(19);
        send(1, 26);
        idle(40);
        served = 4'hF;
        step();
        served = 0;
        repeat (10) begin
            send(0, 7);
            send(3, 7);
        end
        idle(1);
        served = 4'b0001;
        step();
        served = 0;
        idle(2);
        served = 4'hF;
        step();
        served = 0;
        repeat (140) send(0, 3);
        idle(70);
        send(5, 3);
        send(2, 0);
        send(1, 27);
        idle(2);
        repeat (3) send(2, 9);
        served = 4'b0100;
        send(2, 4);
        served = 0;
        check("t6_count2", lane_count[17:12], 0);
        idle(2);
        for (int n = 0; n < 2500; n++) begin
            int r;
            reset = ($urandom % 600) != 0;
            cls_valid = 1'($urandom % 4 != 0);
            cls_lane = ($urandom % 8 < 6) ? 3'($urandom % 4) : 3'($urandom % 8);
            r = $urandom % 8;
            cls_class = r == 0 ? 5'd26 : r == 1 ? 5'($urandom % 32) : 5'(1 + $urandom % 26);
            served = ($urandom % 20 == 0) ? 4'(1 << ($urandom % 4)) : 4'b0;
            step();
        end
        reset = 1;
        cls_valid = 0;
        served = 0;
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
